// File: rtl/contador_parametrico.sv
// rtl/contador_parametrico.sv - parametrised up/down/step/load counter with modulo limit and per-slice RCO
module contador_parametrico #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int STEP  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic [1:0]               modo,
  input  logic [WIDTH-1:0]         D,
  input  logic [WIDTH-1:0]         limite,
  input  logic                     sat,
  output logic [WIDTH-1:0]         Q,
  output logic [WIDTH/SLICE-1:0]   RCO,
  output logic                     valid
);

  localparam int NS = WIDTH / SLICE;
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] q_q, q_d;
  logic [NS-1:0]    rco_q, rco_d;
  logic             valid_q, valid_d;

  // Raw arithmetic is one bit wider so the top slice's carry/borrow is visible
  logic [WIDTH:0]   q_ext, inc_ext, sum, dif;
  logic [WIDTH-1:0] wrap_v;
  logic [NS-1:0]    cy_slice, bw_slice;
  logic             range_evt;

  // Next-state selection: raw add/sub, limit correction and slice carry flags
  always_comb begin
    q_ext   = {1'b0, q_q};
    inc_ext = (modo == 2'b10) ? STEP_EXT : ONE_EXT;
    sum     = q_ext + inc_ext;
    dif     = q_ext - ONE_EXT;
    // Only meaningful when Q <= limite < Q+inc, where the true result is below inc
    wrap_v  = sum[WIDTH-1:0] - limite - WIDTH'(1);
    cy_slice = '0;
    bw_slice = '0;
    // Carry (borrow) into bit k of a+b (a-b) is a[k]^b[k]^result[k]
    for (int i = 0; i < NS; i++) begin
      cy_slice[i] = sum[(i+1)*SLICE] ^ q_ext[(i+1)*SLICE] ^ inc_ext[(i+1)*SLICE];
      bw_slice[i] = dif[(i+1)*SLICE] ^ q_ext[(i+1)*SLICE] ^ ONE_EXT[(i+1)*SLICE];
    end

    q_d       = q_q;
    rco_d     = '0;
    valid_d   = enb;
    range_evt = 1'b0;

    if (enb) begin
      case (modo)
        2'b00, 2'b10: begin
          rco_d = cy_slice;
          if (q_q > limite) begin
            // limite was lowered below the current count
            q_d       = sat ? limite : '0;
            range_evt = 1'b1;
          end else if (sum > {1'b0, limite}) begin
            q_d       = sat ? limite : wrap_v;
            range_evt = 1'b1;
          end else begin
            q_d = sum[WIDTH-1:0];
          end
        end
        2'b01: begin
          rco_d = bw_slice;
          if (q_q > limite) begin
            q_d       = limite;
            range_evt = 1'b1;
          end else if (q_q == '0) begin
            q_d       = sat ? '0 : limite;
            range_evt = 1'b1;
          end else begin
            q_d = dif[WIDTH-1:0];
          end
        end
        default: begin
          // Load is always clamped into range, independent of sat
          q_d = (D <= limite) ? D : limite;
        end
      endcase
      if (range_evt) begin
        rco_d[NS-1] = 1'b1;
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= '0;
      rco_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      rco_q   <= rco_d;
      valid_q <= valid_d;
    end
  end

  assign Q     = q_q;
  assign RCO   = rco_q;
  assign valid = valid_q;

endmodule
